// File: rtl/spi_cfg_ctrl_if.sv
// SPI pin bundle for spi_cfg_ctrl: the external controller is the master,
// the configuration block is the slave.
interface spi_cfg_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;

  modport master (output sclk, output copi, output ncs, input cipo);
  modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: mode-0 SPI configuration receiver feeding a five-entry
// register bank (output enables, PWM enables, PWM duty).
// Frames are 16 bits, MSB first: {write, addr[6:0], data[7:0]}.
// The SPI pins are synchronized into the clk domain; all logic runs on clk.
// Optional feature macro: SPI_READBACK_EN (register readback on cipo).
// Without it, cipo is tied low and no readback logic exists.
module spi_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_cfg_ctrl_if.slave        spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 cfg_valid,
  output logic                 frame_err
);

  localparam logic [6:0] MAX_ADDR_L = MAX_ADDR[6:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;

  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_fall;
  logic                   ncs_rise;

  state_t                 state;
  logic [4:0]             bit_cnt;
  logic [15:0]            shift;
  logic [7:0]             reg_bank [0:4];

  logic                   frame_write;
  logic [6:0]             frame_addr;
  logic [7:0]             frame_data;
  logic                   addr_ok;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  assign frame_write = shift[15];
  assign frame_addr  = shift[14:8];
  assign frame_data  = shift[7:0];
  assign addr_ok     = (frame_addr <= MAX_ADDR_L);

  assign en_reg_out_7_0  = reg_bank[0];
  assign en_reg_out_15_8 = reg_bank[1];
  assign en_reg_pwm_7_0  = reg_bank[2];
  assign en_reg_pwm_15_8 = reg_bank[3];
  assign pwm_duty_cycle  = reg_bank[4];

  // Synchronize the asynchronous SPI pins and keep one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= {SYNC_STAGES{1'b0}};
      copi_sync <= {SYNC_STAGES{1'b0}};
      ncs_sync  <= {SYNC_STAGES{1'b0}};
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  // Frame FSM: collect bits while selected, then commit a well-formed write in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      shift     <= 16'h0000;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        reg_bank[i] <= 8'h00;
      end
    end else begin
      cfg_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A falling ncs seen while committing is deliberately not remembered.
          if (ncs_fall) begin
            bit_cnt <= 5'd0;
            shift   <= 16'h0000;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            shift <= {shift[14:0], copi_s};
            // Saturating at 17 is enough to tell "too long" from exactly 16.
            if (bit_cnt != 5'd17) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (bit_cnt == 5'd16) begin
            if (frame_write && addr_ok) begin
              case (frame_addr)
                7'd0:    reg_bank[0] <= frame_data;
                7'd1:    reg_bank[1] <= frame_data;
                7'd2:    reg_bank[2] <= frame_data;
                7'd3:    reg_bank[3] <= frame_data;
                7'd4:    reg_bank[4] <= frame_data;
                default: ;
              endcase
              cfg_valid <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] rb_sel;
  logic [7:0] rb_shift;
  logic       cipo_r;

  assign sclk_fall = ~sclk_s & sclk_d;
  assign spi.cipo  = cipo_r;

  // Select the register named by the address bits received so far; out-of-range reads return 0.
  always_comb begin
    rb_sel = 8'h00;
    if (shift[6:0] <= MAX_ADDR_L) begin
      case (shift[6:0])
        7'd0:    rb_sel = reg_bank[0];
        7'd1:    rb_sel = reg_bank[1];
        7'd2:    rb_sel = reg_bank[2];
        7'd3:    rb_sel = reg_bank[3];
        7'd4:    rb_sel = reg_bank[4];
        default: rb_sel = 8'h00;
      endcase
    end else begin
      rb_sel = 8'h00;
    end
  end

  // Readback shifter: load after the address byte of a read, then advance on each sclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_shift <= 8'h00;
      cipo_r   <= 1'b0;
    end else if (ncs_s || (state != SHIFT)) begin
      rb_shift <= 8'h00;
      cipo_r   <= 1'b0;
    end else if (sclk_fall) begin
      // After 8 bits the R/W flag sits in shift[7] and the address in shift[6:0].
      if ((bit_cnt == 5'd8) && !shift[7]) begin
        cipo_r   <= rb_sel[7];
        rb_shift <= {rb_sel[6:0], 1'b0};
      end else if ((bit_cnt > 5'd8) && (bit_cnt < 5'd16)) begin
        cipo_r   <= rb_shift[7];
        rb_shift <= {rb_shift[6:0], 1'b0};
      end else begin
        cipo_r   <= 1'b0;
      end
    end
  end
`else
  assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Directed self-checking bench for spi_cfg_ctrl.
module tb_spi_cfg_ctrl;

  localparam int SYNC = 2;

  logic clk;
  logic rst;
  logic [7:0] r0, r1, r2, r3, r4;
  logic cfg_valid;
  logic frame_err;

  int tests;
  int failed;
  logic [15:0] cipo_cap;
  logic [15:0] cipo_exp;

  spi_cfg_ctrl_if bus ();

  spi_cfg_ctrl #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (bus),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .cfg_valid       (cfg_valid),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    check({tag, ".r0"}, {8'h00, r0}, {8'h00, e0});
    check({tag, ".r1"}, {8'h00, r1}, {8'h00, e1});
    check({tag, ".r2"}, {8'h00, r2}, {8'h00, e2});
    check({tag, ".r3"}, {8'h00, r3}, {8'h00, e3});
    check({tag, ".r4"}, {8'h00, r4}, {8'h00, e4});
  endtask

  task automatic wait_clks(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Select the slave and clock out nbits bits (MSB first); ncs stays low afterwards.
  task automatic shift_bits(input logic [15:0] data, input int nbits);
    cipo_cap = 16'h0000;
    @(negedge clk);
    bus.ncs = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      bus.copi = (i < 16) ? data[15 - i] : 1'b0;
      wait_clks(5);
      if (i < 16) cipo_cap[15 - i] = bus.cipo;
      bus.sclk = 1'b1;
      wait_clks(5);
      bus.sclk = 1'b0;
    end
    wait_clks(5);
  endtask

  // Deselect and record cfg_valid for 8 cycles; a commit shows only at cycle SYNC+2.
  task automatic end_frame(input string tag, input logic expect_valid);
    logic [7:0] seen;
    logic [7:0] exp;
    seen = 8'h00;
    bus.ncs = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen[k] = cfg_valid;
    end
    exp = expect_valid ? (8'h01 << (SYNC + 1)) : 8'h00;
    check({tag, ".cfg_valid"}, {8'h00, seen}, {8'h00, exp});
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst      = 1'b1;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;

    // Reset
    wait_clks(5);
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset.cfg_valid", {15'd0, cfg_valid}, 16'h0000);
    check("reset.frame_err", {15'd0, frame_err}, 16'h0000);
    rst = 1'b0;
    wait_clks(6);

    // Two valid writes
    shift_bits(16'h80F0, 16);
    end_frame("wr_80F0", 1'b1);
    shift_bits(16'h8455, 16);
    end_frame("wr_8455", 1'b1);
    check_regs("after_writes", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h55);

    // Out-of-range address, then a read frame
    shift_bits(16'h8AAB, 16);
    end_frame("wr_badaddr", 1'b0);
    shift_bits(16'h0312, 16);
    end_frame("rd_0312", 1'b0);
    check_regs("after_bad_rd", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h55);
    check("after_bad_rd.frame_err", {15'd0, frame_err}, 16'h0000);

    // Short and long frames
    shift_bits(16'h81EE, 10);
    end_frame("short10", 1'b0);
    check("short10.frame_err", {15'd0, frame_err}, 16'h0001);
    shift_bits(16'h81EE, 17);
    end_frame("long17", 1'b0);
    check_regs("after_malformed", 8'hF0, 8'h00, 8'h00, 8'h00, 8'h55);
    check("long17.frame_err", {15'd0, frame_err}, 16'h0001);
    shift_bits(16'h8233, 16);
    end_frame("wr_8233", 1'b1);
    check_regs("after_8233", 8'hF0, 8'h00, 8'h33, 8'h00, 8'h55);
    check("after_8233.frame_err", {15'd0, frame_err}, 16'h0001);

    // Reset in the middle of a frame
    shift_bits(16'h81CC, 12);
    rst = 1'b1;
    wait_clks(3);
    check_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("midrst.frame_err", {15'd0, frame_err}, 16'h0000);
    rst = 1'b0;
    wait_clks(2);
    end_frame("midrst_tail", 1'b0);
    check_regs("midrst_tail", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    shift_bits(16'h81CC, 16);
    end_frame("wr_81CC", 1'b1);
    check_regs("after_81CC", 8'h00, 8'hCC, 8'h00, 8'h00, 8'h00);
    check("after_81CC.frame_err", {15'd0, frame_err}, 16'h0000);

    // Readback of the duty register
    shift_bits(16'h8455, 16);
    end_frame("wr_8455_b", 1'b1);
    check("wr_8455_b.cipo", cipo_cap, 16'h0000);
    shift_bits(16'h0400, 16);
    end_frame("rd_0400", 1'b0);
`ifdef SPI_READBACK_EN
    cipo_exp = 16'h0055;
`else
    cipo_exp = 16'h0000;
`endif
    check("rd_0400.cipo", cipo_cap, cipo_exp);
    check("idle.cipo", {15'd0, bus.cipo}, 16'h0000);
    check_regs("final", 8'h00, 8'hCC, 8'h00, 8'h00, 8'h55);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_cfg_ctrl.md
Name: spi_cfg_ctrl

Overview:
- SPI peripheral (mode 0, write-mostly) that receives 16-bit configuration frames from an external controller.
- Commits frames into a five-entry register bank: output enables, PWM enables, PWM duty.
- Sits between the tile's ui_in pins and the PWM/output datapath of the top-level project; the datapath reads configuration only from this bank.
- All SPI pins are asynchronous to clk; the block synchronizes them and works purely in the clk domain.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchronizer (sclk, copi, ncs); legal range 2..3.
- MAX_ADDR, 4: highest writable register address; frames addressed above it are dropped.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- sclk  input  1  SPI clock, async.
- copi  input  1  SPI data in, async.
- ncs  input  1  SPI chip select, active-low, async.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.
- cfg_valid  output  1  one-clk pulse on each committed write.
- frame_err  output  1  sticky flag; set by a malformed frame.
- cipo  output  1  SPI data out; used only with the optional feature.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- rst clears everything to zero: all five registers, cfg_valid, frame_err, cipo, synchronizers, shift register and bit counter. FSM goes to IDLE.
- Synchronizers: each input passes through SYNC_STAGES flops. Edges are detected on the synchronized sclk and ncs by comparing against a one-cycle-delayed copy.
- Timing requirement: sclk high and low phases must each be at least 4 clk periods. Faster sclk is out of spec.
- Frame format, MSB first, sampled on sclk rising edge:
  - bit15: R/W (1 = write).
  - bits14:8: address.
  - bits7:0: data.
- FSM states:
  - IDLE: on synced ncs falling edge, clear the 5-bit bit counter and the 16-bit shift register, go to SHIFT.
  - SHIFT: on each synced sclk rising edge while ncs is low, shift in the synced copi and increment the counter. The counter saturates at 17. On synced ncs rising edge, go to COMMIT.
  - COMMIT, one cycle:
    - Count == 16, write bit set, address <= MAX_ADDR: update the addressed register and pulse cfg_valid for exactly this cycle.
    - Count == 16, read bit: no register change, no error.
    - Count == 16, address > MAX_ADDR: no change, no error.
    - Count != 16: no change, set frame_err.
    - Always returns to IDLE.
- Latency: registers and cfg_valid update SYNC_STAGES+2 clk cycles after the ncs rising edge at the pin.
- No partial update: a register is never modified mid-frame.
- sclk edges while ncs is high are ignored.
- ncs falling edge while in COMMIT: the COMMIT completes first; the new frame starts at the next ncs falling edge, so back-to-back frames need ncs high for at least 4 clk periods.
- frame_err clears only on rst.
- Reset mid-frame: the frame is discarded and all registers return to 0.
- Unaddressed registers always hold their values.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - In a frame with bit15 = 0, once 8 bits have been received, the addressed register (0 if address > MAX_ADDR) is loaded into an output shift register.
  - Its bits are driven on cipo MSB first, advancing on each synced sclk falling edge, for frame bits 8..15.
  - cipo is 0 when ncs is high.
- Not defined: cipo is tied to 0 and no readback logic is synthesized.

Test Plan:
- Reset: rst high for 5 cycles -> all five registers 0x00, cfg_valid 0, frame_err 0.
- Write 0x80F0 (addr 0x00, data 0xF0), then write 0x8455 (addr 0x04) -> en_reg_out_7_0 = 0xF0, pwm_duty_cycle = 0x55; one cfg_valid pulse per frame, each SYNC_STAGES+2 cycles after ncs rises; other registers stay 0x00.
- Write 0x8AAB (addr 0x0A > MAX_ADDR), then read frame 0x0312 -> no register change, no cfg_valid, frame_err stays 0.
- Abort frame after 10 bits (ncs rises early), then send a 17-bit frame -> no register change, frame_err = 1; a following valid write 0x8233 still sets en_reg_pwm_7_0 = 0x33.
- Assert rst after 12 bits of write 0x81CC -> en_reg_out_15_8 stays 0x00; a next full 0x81CC gives 0xCC.
- With SPI_READBACK_EN defined: write 0x8455, then send read 0x0400 -> cipo shifts 0x55 (0,1,0,1,0,1,0,1) over bits 8..15. Without the macro, cipo stays 0 throughout.
